// File: rtl/demux_pkg.sv
// Shared constants and types for the 2-bit 1-to-4 lane distributor.
package demux_pkg;

   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;

   localparam logic [SEL_W-1:0] LANE_A = 2'd0;
   localparam logic [SEL_W-1:0] LANE_B = 2'd1;
   localparam logic [SEL_W-1:0] LANE_C = 2'd2;
   localparam logic [SEL_W-1:0] LANE_D = 2'd3;

   // Select source: external select or internal rotating pointer.
   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_e;

   // Next lane in rotation order; the last lane wraps back to the first.
   function automatic logic [SEL_W-1:0] lane_next(input logic [SEL_W-1:0] lane);
      return lane + SEL_W'(1);
   endfunction

endpackage

// File: rtl/demux_1_4_2bits_seq_if.sv
// Bundle of the distributor's data, select and per-lane handshake signals.
interface demux_1_4_2bits_seq_if
   import demux_pkg::*;
#(
   parameter int unsigned W = 2
);

   // Upstream side
   logic [W-1:0]     in;
   logic             in_valid;
   logic [SEL_W-1:0] sel_in;
   logic             auto;

   // Downstream consume, one bit per lane
   logic [LANES-1:0] ack;

   // Registered lane outputs and status
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     c;
   logic [W-1:0]     d;
   logic [LANES-1:0] full;
   logic [LANES-1:0] valid;
   logic             drop;
   logic [SEL_W-1:0] sel_out;
   logic             wrap;

   // Drives the distributor and observes its lanes
   modport master (
      output in, in_valid, sel_in, auto, ack,
      input  a, b, c, d, full, valid, drop, sel_out, wrap
   );

   // The distributor itself
   modport slave (
      input  in, in_valid, sel_in, auto, ack,
      output a, b, c, d, full, valid, drop, sel_out, wrap
   );

endinterface

// File: rtl/dwell_ptr.sv
// Rotating lane pointer: follows the external select while in manual mode and,
// in auto mode, dwells DWELL cycles on each lane before stepping to the next.
// DWELL must lie in 1..255 (the dwell counter is 8 bits wide).
module dwell_ptr
   import demux_pkg::*;
#(
   parameter int unsigned DWELL = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             auto,
   input  logic [SEL_W-1:0] sel_in,
   output logic [SEL_W-1:0] ptr,
   output logic             wrap
);

   localparam logic [7:0] CntLast = 8'(DWELL - 1);

   logic [7:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             wrap_q, wrap_d;

   // Next pointer/count. 'auto' is the registered mode, so the cycle that
   // enters auto mode still loads sel_in and the rotation starts from there.
   always_comb begin
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      wrap_d = 1'b0;
      if (!auto) begin
         ptr_d = sel_in;
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         cnt_d  = '0;
         ptr_d  = lane_next(ptr_q);
         wrap_d = (ptr_q == LANE_D);
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Pointer, dwell count and wrap strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         ptr_q  <= LANE_A;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         wrap_q <= wrap_d;
      end
   end

   assign ptr  = ptr_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/demux_1_4_2bits_seq.sv
// Registered 1-to-4 distributor for W-bit words. Each write lands in the lane
// picked by the effective select; a lane stays full until its consumer acks.
module demux_1_4_2bits_seq
   import demux_pkg::*;
#(
   parameter int unsigned W     = 2,
   parameter int unsigned DWELL = 5
) (
   input logic                  clk,
   input logic                  rst,
   demux_1_4_2bits_seq_if.slave bus
);

   mode_e            state_q, state_d;
   logic             in_auto;
   logic [SEL_W-1:0] esel;
   logic [SEL_W-1:0] ptr;
   logic             wrap;

   logic [LANES-1:0] hit;
   logic [LANES-1:0] accept;

   logic [W-1:0]     lane_q [LANES];
   logic [W-1:0]     lane_d [LANES];
   logic [LANES-1:0] full_q, full_d;
   logic [LANES-1:0] valid_q, valid_d;
   logic             drop_q, drop_d;

   // Mode register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MANUAL;
      end else begin
         state_q <= state_d;
      end
   end

   // Mode simply follows the auto input each cycle
   always_comb begin
      state_d = bus.auto ? AUTO : MANUAL;
   end

   // Effective select: external select in manual mode, rotating pointer in auto
   always_comb begin
      in_auto = (state_q == AUTO);
      esel    = bus.sel_in;
      if (in_auto) begin
         esel = ptr;
      end
   end

   dwell_ptr #(
      .DWELL (DWELL)
   ) u_dwell_ptr (
      .clk    (clk),
      .rst    (rst),
      .auto   (in_auto),
      .sel_in (bus.sel_in),
      .ptr    (ptr),
      .wrap   (wrap)
   );

   // Write acceptance: a same-cycle ack frees a full lane for the incoming word
   always_comb begin
      hit     = bus.in_valid ? (LANES'(1) << esel) : '0;
      accept  = hit & (~full_q | bus.ack);
      drop_d  = |(hit & full_q & ~bus.ack);
      valid_d = accept;
      // An accepted write keeps the lane full even if it was acked this cycle
      full_d  = accept | (full_q & ~bus.ack);
      for (int k = 0; k < LANES; k++) begin
         lane_d[k] = accept[k] ? bus.in : lane_q[k];
      end
   end

   // Lane data, full flags and one-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LANES; k++) begin
            lane_q[k] <= '0;
         end
         full_q  <= '0;
         valid_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            lane_q[k] <= lane_d[k];
         end
         full_q  <= full_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.a       = lane_q[LANE_A];
   assign bus.b       = lane_q[LANE_B];
   assign bus.c       = lane_q[LANE_C];
   assign bus.d       = lane_q[LANE_D];
   assign bus.full    = full_q;
   assign bus.valid   = valid_q;
   assign bus.drop    = drop_q;
   assign bus.sel_out = ptr;
   assign bus.wrap    = wrap;

endmodule
